// File: rtl/bar_sweep_scheduler.sv
// Per-frame spectrum-to-bar sweep: reads FFT bins 2..100 once per new frame on vsync,
// averages each bar's bin group, applies an EMA and updates the registered bar bank.
module bar_sweep_scheduler #(
   parameter int GFX_WIDTH = 6,
   parameter int BARS      = 16,
   parameter int FIRST_BIN = 2,
   parameter int LAST_BIN  = 100,
   parameter int ADDR_W    = 7
) (
   input  logic                      clk_25MHz,
   input  logic                      rst,
   input  logic                      vsync,
   input  logic                      fft_done,
   input  logic [1:0]                ema_alpha,
   output logic [ADDR_W-1:0]         bin_addr,
   output logic                      bin_rd,
   input  logic [GFX_WIDTH-1:0]      bin_data,
   output logic                      mem_lock,
   output logic [BARS*GFX_WIDTH-1:0] bars,
   output logic                      sweep_done,
   output logic [7:0]                overrun_cnt
);

   localparam int ACC_W = 11;
   localparam int EMA_W = GFX_WIDTH + 3;

   typedef enum logic [2:0] {IDLE, WAIT_FRAME, READ, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [3:0] bar;
      logic       first;
      logic       last;
      logic [2:0] k;
   } map_t;

   function automatic map_t bin_map(input logic [ADDR_W-1:0] addr);
      map_t m;
      int   a, lo, hi;
      a   = int'(addr);
      lo  = a;
      hi  = a;
      m.bar = 4'd0;
      m.k   = 3'd0;
      if (a <= 8)       begin m.bar = 4'(a - 2); end
      else if (a <= 10) begin m.bar = 4'd7;  m.k = 3'd1; lo = 9;  hi = 10;  end
      else if (a <= 12) begin m.bar = 4'd8;  m.k = 3'd1; lo = 11; hi = 12;  end
      else if (a <= 16) begin m.bar = 4'd9;  m.k = 3'd2; lo = 13; hi = 16;  end
      else if (a <= 20) begin m.bar = 4'd10; m.k = 3'd2; lo = 17; hi = 20;  end
      else if (a <= 28) begin m.bar = 4'd11; m.k = 3'd3; lo = 21; hi = 28;  end
      else if (a <= 36) begin m.bar = 4'd12; m.k = 3'd3; lo = 29; hi = 36;  end
      else if (a <= 52) begin m.bar = 4'd13; m.k = 3'd4; lo = 37; hi = 52;  end
      else if (a <= 68) begin m.bar = 4'd14; m.k = 3'd4; lo = 53; hi = 68;  end
      else              begin m.bar = 4'd15; m.k = 3'd5; lo = 69; hi = 100; end
      m.first = (a == lo);
      m.last  = (a == hi);
      return m;
   endfunction

   function automatic logic [GFX_WIDTH-1:0] avg_of(input logic [ACC_W-1:0] sum,
                                                    input logic [2:0] k);
      return GFX_WIDTH'(sum >> k);
   endfunction

   // (avg + old*(2^a-1)) >> a never exceeds 63, so no clamp is needed
   function automatic logic [GFX_WIDTH-1:0] ema_update(input logic [GFX_WIDTH-1:0] avg,
                                                        input logic [GFX_WIDTH-1:0] old,
                                                        input logic [1:0] a);
      logic [EMA_W-1:0] t;
      t = EMA_W'(avg) + (EMA_W'(old) << a) - EMA_W'(old);
      return GFX_WIDTH'(t >> a);
   endfunction

   state_t                    state_q, state_d;
   logic [1:0]                vs_q, vs_d;
   logic                      pending_q, pending_d;
   logic [7:0]                overrun_q, overrun_d;
   logic                      bin_rd_q, bin_rd_d;
   logic [ADDR_W-1:0]         bin_addr_q, bin_addr_d;
   logic                      mem_lock_q, mem_lock_d;
   logic                      sweep_done_q, sweep_done_d;
   logic                      vld_q, vld_d;
   logic [BARS*GFX_WIDTH-1:0] bars_q, bars_d;
   logic [ADDR_W-1:0]         dat_addr_q, dat_addr_d;
   logic [ACC_W-1:0]          acc_q, acc_d;
   logic [1:0]                alpha_q, alpha_d;
   logic                      vs_rise;
   map_t                      map;
   logic [ACC_W-1:0]          sum;

   assign vs_rise = vs_q[0] & ~vs_q[1];

   always_comb begin
      vs_d         = {vs_q[0], vsync};
      state_d      = state_q;
      pending_d    = pending_q;
      overrun_d    = overrun_q;
      bin_rd_d     = bin_rd_q;
      bin_addr_d   = bin_addr_q;
      mem_lock_d   = mem_lock_q;
      sweep_done_d = 1'b0;
      alpha_d      = alpha_q;
      vld_d        = bin_rd_q;
      dat_addr_d   = bin_addr_q;

      // A frame arriving on the cycle the sweep starts is kept pending, not counted as lost
      if (fft_done) begin
         if (state_q == WAIT_FRAME && vs_rise) begin
            pending_d = 1'b1;
         end else if (pending_q) begin
            if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
         end else begin
            pending_d = 1'b1;
         end
      end else if (state_q == WAIT_FRAME && vs_rise) begin
         pending_d = 1'b0;
      end

      case (state_q)
         IDLE: if (fft_done) state_d = WAIT_FRAME;
         WAIT_FRAME: if (vs_rise) begin
            state_d    = READ;
            bin_rd_d   = 1'b1;
            bin_addr_d = ADDR_W'(FIRST_BIN);
            mem_lock_d = 1'b1;
            alpha_d    = ema_alpha;
         end
         READ: if (bin_addr_q == ADDR_W'(LAST_BIN)) begin
            state_d    = DRAIN;
            bin_rd_d   = 1'b0;
            bin_addr_d = ADDR_W'(FIRST_BIN);
         end else begin
            bin_addr_d = bin_addr_q + ADDR_W'(1);
         end
         DRAIN: begin
            state_d      = DONE;
            mem_lock_d   = 1'b0;
            sweep_done_d = 1'b1;
         end
         DONE: state_d = pending_d ? WAIT_FRAME : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      map    = bin_map(dat_addr_q);
      sum    = (map.first ? '0 : acc_q) + ACC_W'(bin_data);
      acc_d  = vld_q ? sum : acc_q;
      bars_d = bars_q;
      if (vld_q && map.last) begin
         bars_d[map.bar*GFX_WIDTH +: GFX_WIDTH] =
            ema_update(avg_of(sum, map.k), bars_q[map.bar*GFX_WIDTH +: GFX_WIDTH], alpha_q);
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         vs_q         <= 2'b00;
         pending_q    <= 1'b0;
         overrun_q    <= 8'd0;
         bin_rd_q     <= 1'b0;
         bin_addr_q   <= ADDR_W'(FIRST_BIN);
         mem_lock_q   <= 1'b0;
         sweep_done_q <= 1'b0;
         vld_q        <= 1'b0;
         bars_q       <= '0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         bin_rd_q     <= bin_rd_d;
         bin_addr_q   <= bin_addr_d;
         mem_lock_q   <= mem_lock_d;
         sweep_done_q <= sweep_done_d;
         vld_q        <= vld_d;
         bars_q       <= bars_d;
      end
   end

   // Datapath pipeline: address of returning bin, running sum and latched EMA shift
   always_ff @(posedge clk_25MHz) begin
      dat_addr_q <= dat_addr_d;
      acc_q      <= acc_d;
      alpha_q    <= alpha_d;
   end

   assign bin_addr    = bin_addr_q;
   assign bin_rd      = bin_rd_q;
   assign mem_lock    = mem_lock_q;
   assign bars        = bars_q;
   assign sweep_done  = sweep_done_q;
   assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_bar_sweep_scheduler.sv
// Scoreboard bench for bar_sweep_scheduler: stimulus queues expected read addresses and
// bar banks, a negedge monitor pops and compares them as the DUT produces reads and sweep_done.
module tb_bar_sweep_scheduler;

   localparam int GW = 6;
   localparam int NB = 16;
   localparam int AW = 7;
   localparam int BW = NB * GW;
   typedef logic [BW-1:0] bank_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vsync = 1'b0;
   logic          fft_done = 1'b0;
   logic [1:0]    ema_alpha = 2'd0;
   logic [AW-1:0] bin_addr;
   logic          bin_rd;
   logic [GW-1:0] bin_data;
   logic          mem_lock;
   bank_t         bars;
   logic          sweep_done;
   logic [7:0]    overrun_cnt;

   logic [GW-1:0] mem [128];
   logic [AW-1:0] mem_addr_q;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_cnt = 0;
   bit prev_rd = 1'b0;

   logic [AW-1:0] exp_addr[$];
   bank_t         exp_bars[$];

   bar_sweep_scheduler dut (
      .clk_25MHz  (clk),
      .rst        (rst),
      .vsync      (vsync),
      .fft_done   (fft_done),
      .ema_alpha  (ema_alpha),
      .bin_addr   (bin_addr),
      .bin_rd     (bin_rd),
      .bin_data   (bin_data),
      .mem_lock   (mem_lock),
      .bars       (bars),
      .sweep_done (sweep_done),
      .overrun_cnt(overrun_cnt)
   );

   always #20 clk = ~clk;

   // Bin memory with one cycle of read latency
   always @(posedge clk) mem_addr_q <= bin_addr;
   assign bin_data = mem[mem_addr_q];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bank_t act, input bank_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bin_rd) begin
         if (!prev_rd) start_cyc = cyc;
         if (exp_addr.size() == 0) begin
            check("unexpected_bin_rd", bank_t'(bin_rd), bank_t'(0));
         end else begin
            check("bin_addr", bank_t'(bin_addr), bank_t'(exp_addr.pop_front()));
            check("mem_lock_in_read", bank_t'(mem_lock), bank_t'(1));
         end
      end
      prev_rd = bin_rd;
      if (sweep_done) begin
         check("done_latency", bank_t'(cyc - start_cyc), bank_t'(100));
         check("reads_left", bank_t'(exp_addr.size()), bank_t'(0));
         if (exp_bars.size() == 0) check("unexpected_sweep_done", bank_t'(1), bank_t'(0));
         else check("bars", bars, exp_bars.pop_front());
         done_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic fill(input logic [GW-1:0] v);
      for (int i = 0; i < 128; i++) mem[i] = v;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(3);
      exp_addr.delete();
      exp_bars.delete();
      rst = 1'b1;
      tick(2);
   endtask

   task automatic pulse_fft();
      fft_done = 1'b1;
      tick(1);
      fft_done = 1'b0;
      tick(1);
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1;
      tick(3);
      vsync = 1'b0;
      tick(1);
   endtask

   task automatic run_sweep(input logic [1:0] a, input bank_t exp);
      int d0;
      d0 = done_cnt;
      ema_alpha = a;
      for (int i = 2; i <= 100; i++) exp_addr.push_back(AW'(i));
      exp_bars.push_back(exp);
      pulse_fft();
      pulse_vsync();
      for (int t = 0; t < 300 && done_cnt == d0; t++) tick(1);
      tick(3);
      check("sweep_done_pulses", bank_t'(done_cnt - d0), bank_t'(1));
   endtask

   initial begin
      bank_t e;
      bit    found;
      fill(6'd0);
      do_reset();

      // Reset state and vsync without a frame
      check("rst_bin_rd", bank_t'(bin_rd), bank_t'(0));
      check("rst_mem_lock", bank_t'(mem_lock), bank_t'(0));
      check("rst_sweep_done", bank_t'(sweep_done), bank_t'(0));
      check("rst_overrun", bank_t'(overrun_cnt), bank_t'(0));
      check("rst_bars", bars, bank_t'(0));
      check("rst_bin_addr", bank_t'(bin_addr), bank_t'(2));
      pulse_vsync();
      tick(10);
      check("idle_vsync_bars", bars, bank_t'(0));

      // Flat spectrum, a=0
      fill(6'd40);
      run_sweep(2'd0, {NB{6'd40}});

      // Bar 15 averaging over 32 bins, bar 7 truncation
      for (int j = 0; j < 16; j++) begin
         mem[69 + 2*j] = GW'(63 - j);
         mem[70 + 2*j] = GW'(37 + j);
      end
      mem[9]  = 6'd63;
      mem[10] = 6'd0;
      e = {NB{6'd40}};
      e[15*GW +: GW] = 6'd50;
      e[7*GW +: GW]  = 6'd31;
      run_sweep(2'd0, e);

      // EMA with a=2 from a cleared bank, then a second frame
      do_reset();
      fill(6'd48);
      run_sweep(2'd2, {NB{6'd12}});
      run_sweep(2'd2, {NB{6'd21}});

      // Overrun counting and saturation
      do_reset();
      pulse_fft();
      pulse_fft();
      check("overrun_one", bank_t'(overrun_cnt), bank_t'(1));
      repeat (300) pulse_fft();
      check("overrun_sat", bank_t'(overrun_cnt), bank_t'(255));

      // Reset in the middle of the read phase
      do_reset();
      fill(6'd40);
      ema_alpha = 2'd0;
      for (int i = 2; i <= 100; i++) exp_addr.push_back(AW'(i));
      exp_bars.push_back({NB{6'd40}});
      pulse_fft();
      vsync = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         tick(1);
         if (bin_rd) found = 1'b1;
      end
      check("sweep_started", bank_t'(found), bank_t'(1));
      tick(50);
      #8 rst = 1'b0;
      #1;
      check("abort_bin_rd", bank_t'(bin_rd), bank_t'(0));
      check("abort_mem_lock", bank_t'(mem_lock), bank_t'(0));
      check("abort_bars", bars, bank_t'(0));
      exp_addr.delete();
      exp_bars.delete();
      vsync = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(2);
      pulse_vsync();
      tick(10);
      check("post_abort_bars", bars, bank_t'(0));
      run_sweep(2'd0, {NB{6'd40}});

      check("exp_addr_empty", bank_t'(exp_addr.size()), bank_t'(0));
      check("exp_bars_empty", bank_t'(exp_bars.size()), bank_t'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
